// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: per-channel two-flop synchronizer plus stable-interval debounce FSM for active-low buttons.
module btn_debounce_bank #(
  parameter int N = 20,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] btn_n,
  output logic [W-1:0] db_level,
  output logic [W-1:0] db_tick
);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  logic [W-1:0] r_sync1, r_sync2;
  logic [W-1:0] w_lvl, w_tick;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      db_level <= '0;
      db_tick  <= '0;
    end else begin
      r_sync1  <= ~btn_n;
      r_sync2  <= r_sync1;
      db_level <= w_lvl;
      db_tick  <= w_tick;
    end
  end
  for (genvar i = 0; i < W; i++) begin : g_ch
    state_t       r_state, w_next;
    logic [N-1:0] r_cnt, w_cnt;
    logic         w_p, w_tk;
    assign w_p = r_sync2[i];
    always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      w_tk   = 1'b0;
      case (r_state)
        ZERO: if (w_p) begin
          w_next = WAIT1;
          w_cnt  = '1;
        end
        WAIT1: if (!w_p) w_next = ZERO;
          else if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
          else begin
            w_next = ONE;
            w_tk   = 1'b1;
          end
        ONE: if (!w_p) begin
          w_next = WAIT0;
          w_cnt  = '1;
        end
        WAIT0: if (w_p) w_next = ONE;
          else if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
          else w_next = ZERO;
      endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ZERO;
        r_cnt   <= '0;
      end else begin
        r_state <= w_next;
        r_cnt   <= w_cnt;
      end
    end
    // Level and tick are registered from the next state so they change on the same edge as the FSM.
    assign w_lvl[i]  = (w_next == ONE) || (w_next == WAIT0);
    assign w_tick[i] = w_tk;
  end
endmodule

// File: tb/tb_btn_debounce_bank.sv
// tb_btn_debounce_bank: directed latency/bounce/reset scenarios plus random stimulus against a run-length debounce model.
module tb_btn_debounce_bank;
  localparam int N = 3;
  localparam int W = 4;
  localparam int L = (1 << N) + 1;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] btn_n = '1;
  logic [W-1:0] db_level, db_tick;
  int checks = 0, errors = 0, cyc = 0;
  logic [W-1:0] m_s1, m_s2, m_lvl, m_tick;
  int m_run[W];
  int tick_cnt[W];
  int last_tick[W];
  int k, f, r;

  btn_debounce_bank #(.N(N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .db_level(db_level), .db_tick(db_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_tick = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  // The model flips a channel once the synchronized input has disagreed with the level for L consecutive edges.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset_n) begin
      m_tick = '0;
      for (int i = 0; i < W; i++) begin
        m_run[i] = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == L) begin
          m_lvl[i]  = ~m_lvl[i];
          m_tick[i] = m_lvl[i];
          m_run[i]  = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~btn_n;
    end
    #1;
    chk("level", db_level, m_lvl);
    chk("tick", db_tick, m_tick);
    for (int i = 0; i < W; i++) if (db_tick[i] === 1'b1) begin
      tick_cnt[i]++;
      last_tick[i] = cyc;
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin tick_cnt[i] = 0; last_tick[i] = -1; end
    model_reset();
    repeat (3) step();
    chk("reset_level", db_level, 4'b0000);
    chk("reset_tick", db_tick, 4'b0000);
    reset_n = 1'b1;
    repeat (50) step();
    chk("idle_level", db_level, 4'b0000);
    // clean press on channel 0
    btn_n[0] = 1'b0;
    k = cyc + 1;
    repeat (30) step();
    chk_int("press_latency", last_tick[0], k + 10);
    chk_int("press_ticks", tick_cnt[0], 1);
    chk_int("press_other_ticks", tick_cnt[1] + tick_cnt[2] + tick_cnt[3], 0);
    btn_n[0] = 1'b1;
    repeat (20) step();
    chk_int("release_no_tick", tick_cnt[0], 1);
    // bouncing press on channel 2
    f = 0;
    for (int t = 0; t < 20; t++) begin
      if (btn_n[2] == 1'b1 && ((t / 3) % 2) == 0) f = cyc + 1;
      btn_n[2] = ((t / 3) % 2) != 0;
      step();
    end
    chk_int("bounce_no_tick", tick_cnt[2], 0);
    repeat (20) step();
    chk_int("bounce_latency", last_tick[2], f + 10);
    chk_int("bounce_ticks", tick_cnt[2], 1);
    // bouncing release on channel 2
    btn_n[2] = 1'b1;
    repeat (5) step();
    btn_n[2] = 1'b0;
    repeat (2) step();
    btn_n[2] = 1'b1;
    r = cyc + 1;
    while (cyc < r + 9) step();
    chk("release_held", db_level[2], 1'b1);
    step();
    chk("release_fall", db_level[2], 1'b0);
    chk_int("release_bounce_ticks", tick_cnt[2], 1);
    repeat (15) step();
    // simultaneous press
    btn_n = 4'b0000;
    k = cyc + 1;
    while (cyc < k + 10) step();
    chk("simul_tick", db_tick, 4'b1111);
    chk("simul_level", db_level, 4'b1111);
    step();
    chk("simul_tick_fall", db_tick, 4'b0000);
    repeat (20) step();
    chk("held_level", db_level, 4'b1111);
    btn_n = 4'b1111;
    repeat (20) step();
    // reset in the middle of a count on channel 1
    f = tick_cnt[1];
    btn_n[1] = 1'b0;
    k = cyc + 1;
    while (cyc < k + 5) step();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_level", db_level, 4'b0000);
    chk("midreset_tick", db_tick, 4'b0000);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    chk("no_tick_at_k10", db_tick[1], 1'b0);
    while (cyc < k + 20) step();
    chk_int("postreset_latency", last_tick[1], k + 18);
    chk_int("postreset_ticks", tick_cnt[1], f + 1);
    // random slow-toggling buttons, some stable long enough to register
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 6) == 0) btn_n[i] = ~btn_n[i];
      step();
    end
    btn_n = 4'b1111;
    repeat (20) step();
    chk("final_level", db_level, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
